// File: rtl/sim_network_queued.sv
// sim_network_queued
// Simulation endpoint between the NIC streaming ports and the host network
// device. Independent TX and RX FIFOs decouple the DUT ready/valid handshake
// from the per-cycle host tick. A loopback mode routes TX frames straight back
// to RX, and frame counters track completed frames in each direction.
//
// Ports
//   clock, reset                     clock; synchronous active-high reset
//   net_out_valid/ready/bits/last    TX stream from the DUT
//   net_in_valid/ready/bits/last     RX stream to the DUT
//   loopback                         requested mode (1 = loopback, 0 = host)
//   loopback_active                  mode currently in effect
//   net_macAddr                      current MAC address
//   tx_frames, rx_frames             frames accepted from / delivered to the DUT
//
// The host device is reached through host_tick(). The version here is an echo
// host: it accepts a TX word only when RX can take the echo, returns that word
// on the RX side in the same tick, and reports HOST_MAC as its address.
module sim_network_queued #(
  parameter int          DATA_W      = 64,
  parameter int          TX_DEPTH    = 16,
  parameter int          RX_DEPTH    = 16,
  parameter logic [47:0] DEFAULT_MAC = 48'h0,
  parameter logic [47:0] HOST_MAC    = 48'h0A0B0C0D0E0F
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              net_out_valid,
  output logic              net_out_ready,
  input  logic [DATA_W-1:0] net_out_bits,
  input  logic              net_out_last,
  output logic              net_in_valid,
  input  logic              net_in_ready,
  output logic [DATA_W-1:0] net_in_bits,
  output logic              net_in_last,
  input  logic              loopback,
  output logic              loopback_active,
  output logic [47:0]       net_macAddr,
  output logic [31:0]       tx_frames,
  output logic [31:0]       rx_frames
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0]   TX_CNT_ZERO = (TX_AW+1)'(0);
  localparam logic [TX_AW:0]   TX_CNT_ONE  = (TX_AW+1)'(1);
  localparam logic [TX_AW:0]   TX_CNT_FULL = (TX_AW+1)'(TX_DEPTH);
  localparam logic [TX_AW-1:0] TX_PTR_ONE  = (TX_AW)'(1);
  localparam logic [RX_AW:0]   RX_CNT_ZERO = (RX_AW+1)'(0);
  localparam logic [RX_AW:0]   RX_CNT_ONE  = (RX_AW+1)'(1);
  localparam logic [RX_AW:0]   RX_CNT_FULL = (RX_AW+1)'(RX_DEPTH);
  localparam logic [RX_AW-1:0] RX_PTR_ONE  = (RX_AW)'(1);

  // Values returned by one host tick.
  typedef struct packed {
    logic        out_ready;
    logic        in_valid;
    logic [63:0] in_bits;
    logic        in_last;
    logic [47:0] macaddr;
  } host_ret_t;

  // Echo host: takes TX only when RX can accept the echo in the same tick.
  function automatic host_ret_t host_tick(input logic        out_valid,
                                          input logic [63:0] out_bits,
                                          input logic        out_last,
                                          input logic        in_ready);
    host_ret_t r;
    r.out_ready = in_ready;
    r.in_valid  = out_valid;
    r.in_bits   = out_bits;
    r.in_last   = out_last;
    r.macaddr   = HOST_MAC;
    return r;
  endfunction

  // Entries are {last, bits}.
  logic [DATA_W:0]   tx_mem_r [TX_DEPTH];
  logic [TX_AW-1:0]  tx_wr_ptr_r, tx_rd_ptr_r;
  logic [TX_AW:0]    tx_count_r;
  logic [DATA_W:0]   rx_mem_r [RX_DEPTH];
  logic [RX_AW-1:0]  rx_wr_ptr_r, rx_rd_ptr_r;
  logic [RX_AW:0]    rx_count_r;
  logic              tx_mid_r;
  logic              mode_lb_r;
  logic [47:0]       mac_r;
  logic [31:0]       tx_frames_r, rx_frames_r;

  logic [DATA_W:0]   tx_head_s, rx_head_s, rx_push_data_s;
  logic              tx_head_valid_s, rx_full_s;
  logic              tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic              host_call_s;
  logic [63:0]       host_out_bits_s;
  host_ret_t         host_ret_s;

  assign tx_head_s       = tx_mem_r[tx_rd_ptr_r];
  assign rx_head_s       = rx_mem_r[rx_rd_ptr_r];
  assign tx_head_valid_s = (tx_count_r != TX_CNT_ZERO);
  assign rx_full_s       = (rx_count_r == RX_CNT_FULL);
  assign host_call_s     = !reset && !mode_lb_r;

  // Ready comes from the registered count only; a same-cycle pop does not raise it.
  assign net_out_ready   = !reset && (tx_count_r != TX_CNT_FULL);
  assign net_in_valid    = (rx_count_r != RX_CNT_ZERO);
  assign net_in_bits     = rx_head_s[DATA_W-1:0];
  assign net_in_last     = rx_head_s[DATA_W];
  assign tx_push_s       = net_out_valid && net_out_ready;
  assign rx_pop_s        = net_in_valid && net_in_ready;

  assign loopback_active = mode_lb_r;
  assign net_macAddr     = mac_r;
  assign tx_frames       = tx_frames_r;
  assign rx_frames       = rx_frames_r;

  // Host tick arguments and results; TX head zero-extended to 64 bits.
  always_comb begin
    host_out_bits_s = 64'h0;
    host_out_bits_s[DATA_W-1:0] = tx_head_s[DATA_W-1:0];
    host_ret_s = host_tick(tx_head_valid_s, host_out_bits_s, tx_head_s[DATA_W], !rx_full_s);
  end

  // Route the TX head either to the host or straight into RX.
  always_comb begin
    tx_pop_s       = 1'b0;
    rx_push_s      = 1'b0;
    rx_push_data_s = tx_head_s;
    if (mode_lb_r) begin
      tx_pop_s       = !reset && tx_head_valid_s && !rx_full_s;
      rx_push_s      = tx_pop_s;
      rx_push_data_s = tx_head_s;
    end else begin
      tx_pop_s       = host_call_s && tx_head_valid_s && host_ret_s.out_ready;
      // A returned word offered while RX was full is dropped; the host retries.
      rx_push_s      = host_call_s && host_ret_s.in_valid && !rx_full_s;
      rx_push_data_s = {host_ret_s.in_last, host_ret_s.in_bits[DATA_W-1:0]};
    end
  end

  // FIFO storage writes; contents need no reset since counts gate visibility.
  always_ff @(posedge clock) begin
    if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= {net_out_last, net_out_bits};
    if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= rx_push_data_s;
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr_r <= (TX_AW)'(0);
      tx_rd_ptr_r <= (TX_AW)'(0);
      tx_count_r  <= TX_CNT_ZERO;
    end else begin
      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + TX_PTR_ONE;
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + TX_PTR_ONE;
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_count_r <= tx_count_r + TX_CNT_ONE;
        2'b01:   tx_count_r <= tx_count_r - TX_CNT_ONE;
        default: tx_count_r <= tx_count_r;
      endcase
    end
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wr_ptr_r <= (RX_AW)'(0);
      rx_rd_ptr_r <= (RX_AW)'(0);
      rx_count_r  <= RX_CNT_ZERO;
    end else begin
      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + RX_PTR_ONE;
      if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + RX_PTR_ONE;
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_count_r <= rx_count_r + RX_CNT_ONE;
        2'b01:   rx_count_r <= rx_count_r - RX_CNT_ONE;
        default: rx_count_r <= rx_count_r;
      endcase
    end
  end

  // Frame tracking, mode selection, MAC address and frame counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_mid_r    <= 1'b0;
      mode_lb_r   <= 1'b0;
      mac_r       <= DEFAULT_MAC;
      tx_frames_r <= 32'd0;
      rx_frames_r <= 32'd0;
    end else begin
      // tx_mid is set while a frame has been started but its last word not yet taken.
      if (tx_push_s) tx_mid_r <= !net_out_last;
      // Mode only changes with nothing queued and no frame half-sent.
      if ((tx_count_r == TX_CNT_ZERO) && !tx_mid_r) mode_lb_r <= loopback;
      if (host_call_s && (host_ret_s.macaddr != 48'h0)) mac_r <= host_ret_s.macaddr;
      if (tx_push_s && net_out_last) tx_frames_r <= tx_frames_r + 32'd1;
      if (rx_pop_s && rx_head_s[DATA_W]) rx_frames_r <= rx_frames_r + 32'd1;
    end
  end

endmodule

// File: tb/tb_sim_network_queued.sv
// Self-checking bench for sim_network_queued (DATA_W=16, 16/16 FIFOs).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_sim_network_queued;

  localparam int          DW   = 16;
  localparam logic [47:0] DMAC = 48'h020000000001;
  localparam logic [47:0] HMAC = 48'h0A0B0C0D0E0F;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          net_out_valid = 1'b0;
  logic          net_out_ready;
  logic [DW-1:0] net_out_bits = '0;
  logic          net_out_last = 1'b0;
  logic          net_in_valid;
  logic          net_in_ready = 1'b0;
  logic [DW-1:0] net_in_bits;
  logic          net_in_last;
  logic          loopback = 1'b0;
  logic          loopback_active;
  logic [47:0]   net_macAddr;
  logic [31:0]   tx_frames;
  logic [31:0]   rx_frames;

  int checks = 0;
  int errors = 0;
  logic [DW:0] sb[$];

  sim_network_queued #(.DATA_W(DW), .TX_DEPTH(16), .RX_DEPTH(16), .DEFAULT_MAC(DMAC), .HOST_MAC(HMAC)) dut (
    .clock(clock), .reset(reset),
    .net_out_valid(net_out_valid), .net_out_ready(net_out_ready),
    .net_out_bits(net_out_bits), .net_out_last(net_out_last),
    .net_in_valid(net_in_valid), .net_in_ready(net_in_ready),
    .net_in_bits(net_in_bits), .net_in_last(net_in_last),
    .loopback(loopback), .loopback_active(loopback_active),
    .net_macAddr(net_macAddr), .tx_frames(tx_frames), .rx_frames(rx_frames)
  );

  always #5 clock = ~clock;

  // One cycle: sample handshakes just after the falling edge, then advance to the next falling edge.
  task automatic step(output bit acc, output bit pop, output logic [DW:0] got,
                      output bit rdy, output bit hv, output logic [63:0] hw);
    #1;
    acc = net_out_valid && net_out_ready;
    pop = net_in_valid && net_in_ready;
    got = {net_in_last, net_in_bits};
    rdy = net_out_ready;
    hv  = dut.host_call_s && dut.tx_head_valid_s;
    hw  = dut.host_out_bits_s;
    @(negedge clock);
  endtask

  task automatic do_reset(input logic lb);
    reset = 1'b1; net_out_valid = 1'b0; net_out_last = 1'b0; net_in_ready = 1'b0; loopback = lb;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (net_out_ready !== 1'b0) begin errors++; $display("FAIL rst_out_ready got %b exp 0", net_out_ready); end
    checks++; if (net_in_valid !== 1'b0) begin errors++; $display("FAIL rst_in_valid got %b exp 0", net_in_valid); end
    checks++; if (dut.host_call_s !== 1'b0) begin errors++; $display("FAIL rst_no_host_call got %b exp 0", dut.host_call_s); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (net_out_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", net_out_ready); end
    checks++; if (loopback_active !== 1'b0) begin errors++; $display("FAIL rst_lb got %b exp 0", loopback_active); end
    checks++; if (net_macAddr !== DMAC) begin errors++; $display("FAIL rst_mac got %h exp %h", net_macAddr, DMAC); end
    checks++; if (tx_frames !== 32'd0 || rx_frames !== 32'd0) begin errors++; $display("FAIL rst_frames got %0d/%0d exp 0/0", tx_frames, rx_frames); end
    @(negedge clock);
    checks++; if (net_macAddr !== HMAC) begin errors++; $display("FAIL mac_first_tick got %h exp %h", net_macAddr, HMAC); end
  endtask

  task automatic test_host();
    logic [DW:0] words [2];
    logic [DW-1:0] hq[$];
    bit acc, pop, rdy, hv; logic [DW:0] got, exp; logic [63:0] hw;
    int i = 0, npop = 0, nhost = 0;
    words[0] = {1'b0, 16'hBEEF}; words[1] = {1'b1, 16'h1234};
    do_reset(1'b0);
    net_in_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (i < 2) begin net_out_valid = 1'b1; {net_out_last, net_out_bits} = words[i]; end
      else net_out_valid = 1'b0;
      step(acc, pop, got, rdy, hv, hw);
      if (acc) begin sb.push_back(words[i]); hq.push_back(words[i][DW-1:0]); i++; end
      if (hv) begin
        nhost++;
        if (hq.size() == 0) begin errors++; $display("FAIL host_word unexpected %h", hw); end
        else begin
          checks++;
          if (hw !== {48'h0, hq[0]}) begin errors++; $display("FAIL host_word got %h exp %h", hw, {48'h0, hq[0]}); end
          void'(hq.pop_front());
        end
      end
      if (pop) begin
        npop++;
        if (sb.size() == 0) begin errors++; $display("FAIL host_rx unexpected %h", got); end
        else begin exp = sb.pop_front(); checks++;
          if (got !== exp) begin errors++; $display("FAIL host_rx got %h exp %h", got, exp); end end
      end
    end
    checks++; if (nhost != 2 || npop != 2) begin errors++; $display("FAIL host_counts got %0d/%0d exp 2/2", nhost, npop); end
    checks++; if (net_macAddr !== HMAC) begin errors++; $display("FAIL host_mac got %h exp %h", net_macAddr, HMAC); end
    checks++; if (tx_frames !== 32'd1 || rx_frames !== 32'd1) begin errors++; $display("FAIL host_frames got %0d/%0d exp 1/1", tx_frames, rx_frames); end
  endtask

  task automatic test_loopback();
    logic [DW:0] words [3];
    bit acc, pop, rdy, hv; logic [DW:0] got, exp; logic [63:0] hw;
    int i = 0, npop = 0, first_acc = -1, first_pop = -1;
    words[0] = {1'b0, 16'h0011}; words[1] = {1'b0, 16'h0022}; words[2] = {1'b1, 16'h0033};
    do_reset(1'b1);
    for (int c = 0; c < 2; c++) step(acc, pop, got, rdy, hv, hw);
    #1;
    checks++; if (loopback_active !== 1'b1) begin errors++; $display("FAIL lb_active got %b exp 1", loopback_active); end
    net_in_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (i < 3) begin net_out_valid = 1'b1; {net_out_last, net_out_bits} = words[i]; end
      else net_out_valid = 1'b0;
      step(acc, pop, got, rdy, hv, hw);
      if (acc) begin if (first_acc < 0) first_acc = c; sb.push_back(words[i]); i++; end
      if (pop) begin
        npop++; if (first_pop < 0) first_pop = c;
        if (sb.size() == 0) begin errors++; $display("FAIL lb_rx unexpected %h", got); end
        else begin exp = sb.pop_front(); checks++;
          if (got !== exp) begin errors++; $display("FAIL lb_rx got %h exp %h", got, exp); end end
      end
    end
    checks++; if (first_pop != first_acc + 2) begin errors++; $display("FAIL lb_latency got %0d exp %0d", first_pop - first_acc, 2); end
    checks++; if (npop != 3) begin errors++; $display("FAIL lb_npop got %0d exp 3", npop); end
    checks++; if (tx_frames !== 32'd1 || rx_frames !== 32'd1) begin errors++; $display("FAIL lb_frames got %0d/%0d exp 1/1", tx_frames, rx_frames); end
  endtask

  task automatic test_backpressure();
    bit acc, pop, rdy, hv; logic [DW:0] got, exp; logic [63:0] hw;
    int n = 0, npop = 0, first_pop = -1, first_rdy = -1;
    do_reset(1'b1);
    for (int c = 0; c < 2; c++) step(acc, pop, got, rdy, hv, hw);
    for (int c = 0; c < 50; c++) begin
      net_out_valid = 1'b1; net_out_bits = 16'h0100 + DW'(n); net_out_last = (n % 4 == 3);
      step(acc, pop, got, rdy, hv, hw);
      if (acc) begin sb.push_back({(n % 4 == 3), 16'h0100 + DW'(n)}); n++; end
    end
    net_out_valid = 1'b0;
    checks++; if (n != 32) begin errors++; $display("FAIL bp_accepted got %0d exp 32", n); end
    #1;
    checks++; if (net_out_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", net_out_ready); end
    net_in_ready = 1'b1;
    for (int c = 0; c < 45; c++) begin
      step(acc, pop, got, rdy, hv, hw);
      if (pop) begin
        npop++; if (first_pop < 0) first_pop = c;
        if (sb.size() == 0) begin errors++; $display("FAIL bp_rx unexpected %h", got); end
        else begin exp = sb.pop_front(); checks++;
          if (got !== exp) begin errors++; $display("FAIL bp_rx got %h exp %h", got, exp); end end
      end
      if (rdy && first_rdy < 0) first_rdy = c;
    end
    checks++; if (first_pop < 0 || first_rdy != first_pop + 2) begin errors++; $display("FAIL bp_ready_return got %0d exp %0d", first_rdy, first_pop + 2); end
    checks++; if (npop != 32) begin errors++; $display("FAIL bp_npop got %0d exp 32", npop); end
    checks++; if (tx_frames !== 32'd8 || rx_frames !== 32'd8) begin errors++; $display("FAIL bp_frames got %0d/%0d exp 8/8", tx_frames, rx_frames); end
  endtask

  task automatic test_mode_switch();
    logic [DW:0] words [3];
    bit acc, pop, rdy, hv; logic [DW:0] got, exp; logic [63:0] hw;
    int i = 0, a = -1;
    logic exp_lb, obs_lb;
    words[0] = {1'b0, 16'hA001}; words[1] = {1'b0, 16'hA002}; words[2] = {1'b1, 16'hA003};
    do_reset(1'b0);
    net_in_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c >= 2) loopback = 1'b1;
      if (i < 2 || (i == 2 && c >= 6)) begin net_out_valid = 1'b1; {net_out_last, net_out_bits} = words[i]; end
      else net_out_valid = 1'b0;
      #1; obs_lb = loopback_active; #0;
      step(acc, pop, got, rdy, hv, hw);
      exp_lb = (a >= 0) && (c >= a + 3);
      checks++; if (obs_lb !== exp_lb) begin errors++; $display("FAIL ms_active c=%0d got %b exp %b", c, obs_lb, exp_lb); end
      if (acc) begin sb.push_back(words[i]); if (i == 2) a = c; i++; end
      if (pop) begin
        if (sb.size() == 0) begin errors++; $display("FAIL ms_rx unexpected %h", got); end
        else begin exp = sb.pop_front(); checks++;
          if (got !== exp) begin errors++; $display("FAIL ms_rx got %h exp %h", got, exp); end end
      end
    end
    checks++; if (a != 6) begin errors++; $display("FAIL ms_last_accept got %0d exp 6", a); end
  endtask

  task automatic test_wrap();
    bit acc, pop, rdy, hv; logic [DW:0] got; logic [63:0] hw;
    do_reset(1'b0);
    net_in_ready = 1'b1;
    force dut.tx_frames_r = 32'hFFFF_FFFF;
    #1;
    release dut.tx_frames_r;
    checks++; if (tx_frames !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset got %h exp ffffffff", tx_frames); end
    net_out_valid = 1'b1; net_out_bits = 16'h00AA; net_out_last = 1'b1;
    step(acc, pop, got, rdy, hv, hw);
    net_out_valid = 1'b0; net_out_last = 1'b0;
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL wrap_accept got %b exp 1", acc); end
    checks++; if (tx_frames !== 32'd0) begin errors++; $display("FAIL wrap_value got %h exp 0", tx_frames); end
    for (int c = 0; c < 4; c++) step(acc, pop, got, rdy, hv, hw);
  endtask

  task automatic test_reset_mid();
    logic [DW:0] words [3];
    bit acc, pop, rdy, hv; logic [DW:0] got, exp; logic [63:0] hw;
    int i = 0, n = 0;
    words[0] = {1'b0, 16'h0201}; words[1] = {1'b1, 16'h0202}; words[2] = {1'b1, 16'h0203};
    do_reset(1'b1);
    for (int c = 0; c < 2; c++) step(acc, pop, got, rdy, hv, hw);
    net_in_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (i < 3) begin net_out_valid = 1'b1; {net_out_last, net_out_bits} = words[i]; end
      else net_out_valid = 1'b0;
      step(acc, pop, got, rdy, hv, hw);
      if (acc) begin sb.push_back(words[i]); i++; end
      if (pop) begin
        if (sb.size() == 0) begin errors++; $display("FAIL rm_rx unexpected %h", got); end
        else begin exp = sb.pop_front(); checks++;
          if (got !== exp) begin errors++; $display("FAIL rm_rx got %h exp %h", got, exp); end end
      end
    end
    checks++; if (rx_frames !== 32'd2) begin errors++; $display("FAIL rm_pre_frames got %0d exp 2", rx_frames); end
    net_in_ready = 1'b0;
    for (int c = 0; c < 10 && n < 5; c++) begin
      net_out_valid = 1'b1; net_out_bits = 16'h0301 + DW'(n); net_out_last = 1'b0;
      step(acc, pop, got, rdy, hv, hw);
      if (acc) n++;
    end
    net_out_valid = 1'b0;
    checks++; if (n != 5) begin errors++; $display("FAIL rm_queued got %0d exp 5", n); end
    reset = 1'b1;
    #1;
    checks++; if (net_out_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_reset got %b exp 0", net_out_ready); end
    @(negedge clock);
    #1;
    checks++; if (net_in_valid !== 1'b0 || dut.tx_count_r !== 5'd0) begin errors++; $display("FAIL rm_fifos got %b/%0d exp 0/0", net_in_valid, dut.tx_count_r); end
    checks++; if (tx_frames !== 32'd0 || rx_frames !== 32'd0) begin errors++; $display("FAIL rm_frames got %0d/%0d exp 0/0", tx_frames, rx_frames); end
    checks++; if (net_macAddr !== DMAC) begin errors++; $display("FAIL rm_mac got %h exp %h", net_macAddr, DMAC); end
    checks++; if (dut.host_call_s !== 1'b0) begin errors++; $display("FAIL rm_no_host_call got %b exp 0", dut.host_call_s); end
    reset = 1'b0;
    #1;
    checks++; if (net_out_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_after got %b exp 1", net_out_ready); end
    sb.delete();
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_host();
    test_loopback();
    test_backpressure();
    test_mode_switch();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sim_network_queued.md
# sim_network_queued

Simulation-only network endpoint that connects the NIC's 64-bit-class streaming ports to a host network device through DPI, with parametrised data width and independent TX/RX FIFOs. The FIFOs decouple the DUT handshake from the host call, so the DUT sees a proper ready/valid protocol at full throughput.

The block also carries frame boundaries (`last`), keeps frame counters, and has a loopback mode that routes TX frames back to RX without the host. It instantiates in the simulation top-level in place of the single-register network shim.

## Interface

**Parameters**
- `DATA_W`, 64: payload width; a multiple of 8, from 8 to 64. It is zero-extended to 64 toward the host and truncated from 64 coming back.
- `TX_DEPTH`, 16: TX FIFO entries; a power of 2, at least 2.
- `RX_DEPTH`, 16: RX FIFO entries; a power of 2, at least 2.
- `DEFAULT_MAC`, 48'h0: MAC address presented from reset until the host supplies one.

**Ports**
- `clock`  in  1  clock; reset is synchronous, active-high.
- `reset`  in  1  synchronous, active-high reset.
- `net_out_valid`  in  1  DUT has a TX word.
- `net_out_ready`  out  1  block accepts the TX word.
- `net_out_bits`  in  DATA_W  TX payload.
- `net_out_last`  in  1  TX word ends its frame.
- `net_in_valid`  out  1  RX word available.
- `net_in_ready`  in  1  DUT accepts the RX word.
- `net_in_bits`  out  DATA_W  RX payload.
- `net_in_last`  out  1  RX word ends its frame.
- `loopback`  in  1  requested mode: 1 = loopback, 0 = host.
- `loopback_active`  out  1  mode currently in effect.
- `net_macAddr`  out  48  current MAC address.
- `tx_frames`  out  32  count of TX frames accepted from the DUT.
- `rx_frames`  out  32  count of RX frames delivered to the DUT.

## Operation

**TX FIFO**
- Each entry is {last, bits}.
- Push on `net_out_valid && net_out_ready`.
- `net_out_ready = !reset && tx_count != TX_DEPTH`.
- `net_out_ready` is derived from the registered count only. A pop in the same cycle does not raise it.

**RX FIFO**
- Each entry is {last, bits}.
- Pop on `net_in_valid && net_in_ready`.
- `net_in_valid = rx_count != 0`.
- `net_in_bits` and `net_in_last` show the FIFO head. They are don't-care while `net_in_valid` is 0.

**Mode register `mode_lb`**
- Loads from `loopback` only on a cycle where the TX FIFO is empty and no TX frame is partially enqueued (tracked by a `tx_mid` flag).
- Otherwise it holds, so a frame is never split across destinations.
- `loopback_active = mode_lb`.

**Host mode (`mode_lb = 0`)** — on every non-reset cycle, call the DPI tick with:
- out_valid = TX head valid.
- out_bits = head zero-extended, with `last` in the host's frame-end argument.
- in_ready = RX not full.

The call returns out_ready, in_valid, in_bits, in_last and macaddr. In the same edge:
- Pop TX if out_valid && out_ready.
- Push RX if in_valid && in_ready.
- A returned in_valid while the block presented in_ready = 0 is ignored; the host must retry.

**Loopback mode (`mode_lb = 1`)**
- No DPI tick is issued.
- At most one word per cycle moves from the TX head to RX, when TX is non-empty and RX is not full.

**MAC address**
- `net_macAddr` resets to `DEFAULT_MAC`.
- In host mode it loads the returned macaddr[47:0] whenever that value is non-zero.

**Frame counters**
- `tx_frames` increments on an accepted DUT word with `net_out_last = 1`.
- `rx_frames` increments on a popped word with `net_in_last = 1`.
- Both wrap modulo 2^32.

**Simultaneous push and pop** on either FIFO leave the count unchanged and are legal when full or empty, except for the `net_out_ready` rule above.

## Timing

**Reset values**
- `net_out_ready` = 0 and `net_in_valid` = 0.
- Both FIFOs empty; `tx_mid` = 0.
- `mode_lb` / `loopback_active` = 0.
- `net_macAddr` = `DEFAULT_MAC`.
- Both counters = 0.
- Reset mid-frame discards all FIFO contents. No DPI call is made while reset is high.

**Latency**
- A DUT word accepted in cycle k is at the TX head in cycle k+1.
- In loopback with RX space, it appears on `net_in_*` in cycle k+2.
- A host-returned word pushed at the edge ending cycle k is visible on `net_in_*` in cycle k+1.

**Throughput and mode switching**
- Steady state is 1 word/cycle in each direction when neither side stalls.
- A mode change takes effect the cycle after the qualifying idle cycle.

## Test plan

- **Loopback single frame**: `loopback=1`, idle 2 cycles, then send 3 words 0x11, 0x22, 0x33 with last on 0x33, `net_in_ready=1` -> the same words and last appear in order starting 2 cycles after the first accept; `tx_frames=1`, `rx_frames=1`.
- **Backpressure to full**: loopback, `net_in_ready=0`, defaults 16/16 -> exactly 32 words accepted, then `net_out_ready=0`. Raising `net_in_ready` drains all 32 in order; `net_out_ready` returns 1 two cycles after the first pop.
- **Mode switch mid-frame**: enqueue 2 words without last, toggle `loopback` to 1 -> `loopback_active` stays 0 until the last word is accepted and the TX FIFO drains, then goes 1.
- **DATA_W=16 host mode**: the host stub echoes each word and returns macaddr 0x0A0B0C0D0E0F. DUT sends 0xBEEF -> the host sees 0x000000000000BEEF; `net_macAddr=0x0A0B0C0D0E0F` one cycle after the first tick; RX delivers 0xBEEF.
- **Reset mid-operation**: loopback with 5 words queued and `rx_frames=2`, assert reset for 1 cycle -> FIFOs empty, counters 0, `net_out_ready=0` during reset and 1 the cycle after, MAC equals `DEFAULT_MAC`.
- **Counter wrap**: force `tx_frames` to 0xFFFFFFFF, accept one last-word -> `tx_frames=0`.
